// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared data-memory port arbiter between fetch and execute
module mem_port_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int LAT      = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ex_req,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W/8-1:0] ex_we,
  input  logic [DATA_W-1:0]   ex_wdata,
  output logic                ex_gnt,
  output logic                ex_rvalid,
  output logic [DATA_W-1:0]   ex_rdata,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic {NORMAL, STARVE} prio_e;

  prio_e            state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

  // Response tags: index 0 is written at grant, index LAT lines up with mem_rdata.
  logic [LAT:0] tag_vld;
  logic [LAT:0] tag_ex;
  logic         push_vld;
  logic         push_ex;

  // Grant selection, starvation counting and priority-state transitions.
  always_comb begin
    if_gnt       = 1'b0;
    ex_gnt       = 1'b0;
    wait_cnt_nxt = wait_cnt;
    state_nxt    = state;
    case (state)
      NORMAL: begin
        ex_gnt = ex_req;
        if_gnt = if_req && !ex_req;
      end
      STARVE: begin
        if_gnt = if_req;
      end
      default: ;
    endcase
    if (!if_req || if_gnt) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
    case (state)
      NORMAL: if (wait_cnt_nxt == CNT_MAX) state_nxt = STARVE;
      STARVE: if (if_gnt || !if_req) state_nxt = NORMAL;
      default: state_nxt = NORMAL;
    endcase
  end

  // Priority state and starvation counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Register the winning command; addr/wdata hold when idle so the port toggles less.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= if_gnt || ex_gnt;
      if (ex_gnt) begin
        mem_addr  <= ex_addr;
        mem_we    <= ex_we;
        mem_wdata <= ex_wdata;
      end else if (if_gnt) begin
        mem_addr <= if_addr;
        mem_we   <= '0;
      end else begin
        mem_we <= '0;
      end
    end
  end

  // Only reads produce a response; stores enter the pipeline as empty slots.
  always_comb begin
    push_ex  = ex_gnt;
    push_vld = if_gnt || (ex_gnt && (ex_we == '0));
  end

  // Tag shift register; a flush kills every fetch-owned slot, including the new one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld <= '0;
      tag_ex  <= '0;
    end else begin
      tag_vld[0] <= push_vld && !(if_flush && !push_ex);
      tag_ex[0]  <= push_ex;
      for (int k = 1; k <= LAT; k++) begin
        tag_vld[k] <= tag_vld[k-1] && !(if_flush && !tag_ex[k-1]);
        tag_ex[k]  <= tag_ex[k-1];
      end
    end
  end

  // Steer the head-of-pipeline response to its owner; data is a straight pass-through.
  always_comb begin
    if_rvalid = tag_vld[LAT] && !tag_ex[LAT] && !if_flush;
    ex_rvalid = tag_vld[LAT] && tag_ex[LAT];
    if_rdata  = mem_rdata;
    ex_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int BE_W     = DATA_W / 8;
  localparam int LAT      = 2;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              if_req, if_flush, ex_req;
  logic [ADDR_W-1:0] if_addr, ex_addr;
  logic [BE_W-1:0]   ex_we;
  logic [DATA_W-1:0] ex_wdata, mem_rdata;
  logic              if_gnt, if_rvalid, ex_gnt, ex_rvalid, mem_en;
  logic [DATA_W-1:0] if_rdata, ex_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_we;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ex_req(ex_req), .ex_addr(ex_addr), .ex_we(ex_we), .ex_wdata(ex_wdata),
    .ex_gnt(ex_gnt), .ex_rvalid(ex_rvalid), .ex_rdata(ex_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   we;
    logic [DATA_W-1:0] wd;
  } cmd_t;

  typedef struct {
    int                due;
    bit                own_ex;
    logic [DATA_W-1:0] data;
  } rsp_t;

  cmd_t              cmd_q[$];
  rsp_t              rsp_q[$];
  logic [ADDR_W-1:0] mem_hist[int];

  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  int                m_cnt    = 0;
  bit                m_starve = 1'b0;
  logic [DATA_W-1:0] m_wdata  = '0;
  int                ex_gnt_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[31:0] ^ 32'hC0FFEE11, ~a[31:0]};
  endfunction

  task automatic step(input bit ir, input logic [ADDR_W-1:0] ia, input bit fl,
                      input bit er, input logic [ADDR_W-1:0] ea,
                      input logic [BE_W-1:0] we, input logic [DATA_W-1:0] wd);
    bit   exp_if, exp_ex, exp_iv, exp_xv, exp_en, is_read;
    int   ncnt;
    cmd_t c;
    rsp_t r;
    if_req = ir; if_addr = ia; if_flush = fl;
    ex_req = er; ex_addr = ea; ex_we = we; ex_wdata = wd;
    mem_rdata = mem_hist.exists(cyc - LAT) ? mem_word(mem_hist[cyc - LAT]) : 64'h0;
    @(negedge clk);

    exp_ex = !m_starve && er;
    exp_if = ir && (m_starve || !er);
    check("if_gnt", 64'(if_gnt), 64'(exp_if));
    check("ex_gnt", 64'(ex_gnt), 64'(exp_ex));
    if (ex_gnt) ex_gnt_cnt++;

    if (fl) begin
      for (int i = rsp_q.size() - 1; i >= 0; i--)
        if (!rsp_q[i].own_ex && rsp_q[i].due >= cyc) rsp_q.delete(i);
    end
    exp_iv = (rsp_q.size() > 0) && (rsp_q[0].due == cyc) && !rsp_q[0].own_ex;
    exp_xv = (rsp_q.size() > 0) && (rsp_q[0].due == cyc) && rsp_q[0].own_ex;
    check("if_rvalid", 64'(if_rvalid), 64'(exp_iv));
    check("ex_rvalid", 64'(ex_rvalid), 64'(exp_xv));
    if (exp_iv) check("if_rdata", if_rdata, rsp_q[0].data);
    if (exp_xv) check("ex_rdata", ex_rdata, rsp_q[0].data);
    if (exp_iv || exp_xv) void'(rsp_q.pop_front());

    exp_en = (cmd_q.size() > 0) && (cmd_q[0].cyc == cyc);
    check("mem_en", 64'(mem_en), 64'(exp_en));
    if (exp_en) begin
      c = cmd_q.pop_front();
      check("mem_addr", mem_addr, c.addr);
      check("mem_we", 64'(mem_we), 64'(c.we));
      check("mem_wdata", mem_wdata, c.wd);
    end else begin
      check("mem_we_idle", 64'(mem_we), 64'h0);
    end
    if (mem_en && mem_we == '0) mem_hist[cyc] = mem_addr;

    if (exp_ex) m_wdata = wd;
    if (exp_if || exp_ex) begin
      c.cyc  = cyc + 1;
      c.addr = exp_ex ? ea : ia;
      c.we   = exp_ex ? we : '0;
      c.wd   = m_wdata;
      cmd_q.push_back(c);
    end
    is_read = exp_if || (exp_ex && we == '0);
    if (is_read && !(exp_if && fl)) begin
      r.due    = cyc + 1 + LAT;
      r.own_ex = exp_ex;
      r.data   = mem_word(exp_ex ? ea : ia);
      rsp_q.push_back(r);
    end

    ncnt = (!ir || exp_if) ? 0 : ((m_cnt < MAX_WAIT) ? m_cnt + 1 : MAX_WAIT);
    if (!m_starve) m_starve = (ncnt == MAX_WAIT);
    else           m_starve = !(exp_if || !ir);
    m_cnt = ncnt;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic reset_now();
    rstn = 1'b0;
    if_req = 0; ex_req = 0; if_flush = 0;
    #1;
    check("rst_mem_en", 64'(mem_en), 64'h0);
    check("rst_mem_we", 64'(mem_we), 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_if_rvalid", 64'(if_rvalid), 64'h0);
    check("rst_ex_rvalid", 64'(ex_rvalid), 64'h0);
    cmd_q.delete(); rsp_q.delete(); mem_hist.delete();
    m_cnt = 0; m_starve = 0; m_wdata = '0;
    @(posedge clk);
    #1;
    cyc++;
    rstn = 1'b1;
  endtask

  initial begin
    if_req = 0; if_addr = '0; if_flush = 0;
    ex_req = 0; ex_addr = '0; ex_we = '0; ex_wdata = '0; mem_rdata = '0;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    reset_now();
    idle(3);

    // Single fetch read at 0x10.
    step(1, 64'h10, 0, 0, '0, '0, '0);
    idle(4);

    // Continuous contention: ex x4 then if, repeating.
    ex_gnt_cnt = 0;
    for (int i = 0; i < 15; i++) step(1, 64'h100 + 64'(i), 0, 1, 64'h200 + 64'(i), '0, '0);
    check("contention_ex_count", 64'(ex_gnt_cnt), 64'd12);
    idle(4);

    // Store: no response ever.
    step(0, '0, 0, 1, 64'h40, 8'hFF, 64'hDEADBEEF);
    idle(4);

    // Two fetch reads, then an execute load with flush.
    step(1, 64'h300, 0, 0, '0, '0, '0);
    step(1, 64'h308, 0, 0, '0, '0, '0);
    step(0, '0, 1, 1, 64'h500, '0, '0);
    idle(4);

    // Flush with empty pipeline.
    step(0, '0, 1, 0, '0, '0, '0);
    idle(2);

    // Execute alone for ten cycles.
    ex_gnt_cnt = 0;
    for (int i = 0; i < 10; i++) step(0, '0, 0, 1, 64'h600 + 64'(i), '0, '0);
    check("ex_alone_count", 64'(ex_gnt_cnt), 64'd10);
    idle(3);

    // Fetch withdraws before being granted.
    step(1, 64'h700, 0, 1, 64'h800, '0, '0);
    step(0, 64'h700, 0, 1, 64'h808, '0, '0);
    idle(4);

    // Random mix.
    for (int i = 0; i < 300; i++) begin
      logic [BE_W-1:0] rwe;
      rwe = ($urandom_range(0, 1) == 1) ? BE_W'($urandom) : '0;
      step(bit'($urandom_range(0, 1)), 64'({$urandom, $urandom}),
           ($urandom_range(0, 7) == 0),
           bit'($urandom_range(0, 1)), 64'({$urandom, $urandom}),
           rwe, 64'({$urandom, $urandom}));
    end
    idle(4);

    // Reset with two reads in flight.
    step(1, 64'h900, 0, 0, '0, '0, '0);
    step(0, '0, 0, 1, 64'hA00, '0, '0);
    reset_now();
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous data-memory port between the instruction-fetch stage and the execute-stage load/store unit. Grants one request per cycle, with execute priority and a starvation guard for fetch. Registers the winning command onto the memory port and routes read data back to its owner after the fixed memory latency. Drops fetch responses in flight when a taken branch flushes the front end.

## Interface
- ADDR_W, 64, word address width (byte offset already stripped by requester)
- DATA_W, 64, memory data width; byte-enable width is DATA_W/8
- LAT, 2, memory read latency in cycles from mem_en to valid mem_rdata (>=1)
- MAX_WAIT, 4, consecutive cycles fetch may be denied before it is forced to win (>=1)

- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_flush  in  1  cancel all in-flight fetch reads (taken branch)
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- ex_req  in  1  execute access request; held until ex_gnt
- ex_addr  in  ADDR_W  execute word address
- ex_we  in  DATA_W/8  byte write enables; all zero = load
- ex_wdata  in  DATA_W  store data
- ex_gnt  out  1  execute request accepted this cycle
- ex_rvalid  out  1  ex_rdata valid (loads only)
- ex_rdata  out  DATA_W  load data
- mem_en  out  1  memory command valid
- mem_addr  out  ADDR_W  memory word address
- mem_we  out  DATA_W/8  memory byte write enables
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid LAT cycles after mem_en of a read

## Operation
- Grant (combinational from req and state): at most one of if_gnt/ex_gnt per cycle.
  - Priority state NORMAL: ex_req wins; else if_req wins.
  - Priority state STARVE: if_req wins; ex_gnt=0.
- Starvation counter wait_cnt (width clog2(MAX_WAIT+1)): increments when if_req && !if_gnt; clears when if_gnt or !if_req; saturates at MAX_WAIT.
- FSM: NORMAL -> STARVE when next wait_cnt reaches MAX_WAIT; STARVE -> NORMAL on if_gnt or when if_req drops (withdrawn request).
- Issue register: on a grant, next cycle mem_en=1 with winner's addr; mem_we=ex_we and mem_wdata=ex_wdata for execute, mem_we=0 for fetch. No grant -> mem_en=0, mem_we=0 (addr/wdata hold last value).
- Response tag pipeline, depth LAT+1, entry {valid, owner}: pushed at grant with valid=1 only for reads (fetch, or execute with ex_we==0). Stores never produce ex_rvalid.
- Output at pipeline head: if_rvalid/ex_rvalid = head valid && owner matches; if_rdata = ex_rdata = mem_rdata (pass-through).
- Flush: while if_flush=1, every fetch-owned entry in the pipeline, including one pushed by an if_gnt in the same cycle, has valid cleared; if_rvalid forced 0 that cycle. Execute entries untouched. Grants are not suppressed by flush.

## Timing
- Grant-to-command: 1 cycle (grant at t, mem_en at t+1).
- Grant-to-response: LAT+1 cycles (read granted at t -> rvalid at t+1+LAT).
- Throughput: one access per cycle, back-to-back, any owner mix; responses in grant order.
- Reset (rstn low, asynchronous): mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rvalid=0, ex_rvalid=0, tag pipeline cleared, wait_cnt=0, FSM=NORMAL. In-flight responses are discarded; if_gnt/ex_gnt follow their combinational rule from reset state.
- Boundary: requester dropping req before grant -> no command; MAX_WAIT=1 -> fetch wins every second cycle under continuous contention; flush with empty pipeline is a no-op.

## Test plan
- Continuous ex_req and if_req, MAX_WAIT=4 -> grant pattern ex,ex,ex,ex,if repeating; mem_en high every cycle.
- Single fetch read at addr 0x10 granted at cycle 5, LAT=2 -> mem_en/mem_addr=0x10 at cycle 6, if_rvalid with mem_rdata at cycle 8, ex_rvalid stays 0.
- Execute store ex_we=0xFF, ex_wdata=0xDEADBEEF -> mem_we=0xFF, mem_wdata=0xDEADBEEF one cycle after ex_gnt; no ex_rvalid ever.
- Interleaved fetch reads at cycles 1,2 and execute load at 3, if_flush at cycle 3 -> only ex_rvalid at cycle 6; if_rvalid never asserts.
- rstn low during cycle with two reads in flight -> mem_en and both rvalids 0 immediately, no response after rstn returns high.
- Both requesters idle then ex_req alone for 10 cycles while if_req=0 -> wait_cnt stays 0, FSM stays NORMAL, ten ex_gnt.
